if_prefetch_unit: RTL and testbench

Parametrised instruction-fetch stage with an in-order prefetch queue in front of a request/grant/response instruction memory. It replaces the single-register fetch PC with decoupled fetch, so the IF stage keeps fetching while ID is stalled. It resolves JR/J/branch redirects with fixed priority, squashes queued and in-flight fetches, and presents one instruction per cycle to the IF/ID register.

---
 rtl/if_prefetch_unit.sv | 136 +++++++++++++
 tb/tb_if_prefetch_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_unit.sv
// rtl/if_prefetch_unit.sv - decoupled instruction fetch with in-order prefetch queue
// Redirects squash queued slots and count in-flight responses so they can be discarded on return.
module if_prefetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Z,
  input  logic              J,
  input  logic              JR,
  input  logic [ADDR_W-1:0] JumpAddr,
  input  logic [ADDR_W-1:0] JrAddr,
  input  logic [ADDR_W-1:0] BranchAddr,
  input  logic              PC_IFWrite,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [DATA_W-1:0] Instruction_if,
  output logic [ADDR_W-1:0] NextPC_if,
  output logic              IF_flush
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  alloc_ptr_q, alloc_ptr_d;
  logic [PTR_W-1:0]  fill_ptr_q, fill_ptr_d;
  logic [PTR_W-1:0]  head_ptr_q, head_ptr_d;
  logic [PTR_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [ADDR_W-1:0] slot_pc_q   [DEPTH];
  logic [DATA_W-1:0] slot_data_q [DEPTH];
  logic [DEPTH-1:0]  slot_filled_q;

  logic [PTR_W-1:0]  alloc_cnt, unfilled_cnt, outstanding;
  logic [IDX_W-1:0]  head_idx, alloc_idx, fill_idx;
  logic [ADDR_W-1:0] target;
  logic              redirect, grant, fill, drop, pop, rsp_live, head_alloc;

  assign alloc_cnt    = alloc_ptr_q - head_ptr_q;
  assign unfilled_cnt = alloc_ptr_q - fill_ptr_q;
  assign outstanding  = unfilled_cnt + drop_cnt_q;
  assign head_idx     = head_ptr_q[IDX_W-1:0];
  assign alloc_idx    = alloc_ptr_q[IDX_W-1:0];
  assign fill_idx     = fill_ptr_q[IDX_W-1:0];

  assign redirect = !reset && (Z || J || JR);
  assign IF_flush = redirect;

  // Pending drops hold credit so late responses never find their slot reused.
  assign imem_req  = !reset && !redirect &&
                     (({1'b0, alloc_cnt} + {1'b0, drop_cnt_q}) < CNT_W'(DEPTH));
  assign imem_addr = pc_q;
  assign grant     = imem_req && imem_gnt;

  assign drop     = !reset && imem_rvalid && (drop_cnt_q != '0);
  assign fill     = !reset && !redirect && imem_rvalid &&
                    (drop_cnt_q == '0) && (unfilled_cnt != '0);
  assign rsp_live = imem_rvalid && (outstanding != '0);

  assign head_alloc     = (head_ptr_q != alloc_ptr_q);
  assign if_valid       = !reset && head_alloc && slot_filled_q[head_idx];
  assign pop            = if_valid && PC_IFWrite && !redirect;
  assign Instruction_if = if_valid ? slot_data_q[head_idx] : '0;
  assign NextPC_if      = if_valid ? (slot_pc_q[head_idx] + ADDR_W'(4)) : '0;

  always_comb begin
    target = BranchAddr;
    if (JR) begin
      target = JrAddr;
    end else if (J) begin
      target = JumpAddr;
    end
  end

  always_comb begin
    pc_d        = pc_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    drop_cnt_d  = drop_cnt_q;
    if (redirect) begin
      pc_d        = {target[ADDR_W-1:2], 2'b00};
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
      drop_cnt_d  = outstanding - PTR_W'(rsp_live);
    end else begin
      if (grant) begin
        pc_d        = pc_q + ADDR_W'(4);
        alloc_ptr_d = alloc_ptr_q + PTR_W'(1);
      end
      if (fill) fill_ptr_d = fill_ptr_q + PTR_W'(1);
      if (pop)  head_ptr_d = head_ptr_q + PTR_W'(1);
      if (drop) drop_cnt_d = drop_cnt_q - PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      alloc_ptr_q   <= '0;
      fill_ptr_q    <= '0;
      head_ptr_q    <= '0;
      drop_cnt_q    <= '0;
      slot_filled_q <= '0;
    end else begin
      pc_q        <= pc_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      drop_cnt_q  <= drop_cnt_d;
      if (redirect) begin
        slot_filled_q <= '0;
      end else begin
        if (grant) slot_filled_q[alloc_idx] <= 1'b0;
        if (fill)  slot_filled_q[fill_idx]  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !redirect) begin
      if (grant) slot_pc_q[alloc_idx]  <= pc_q;
      if (fill)  slot_data_q[fill_idx] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// tb/tb_if_prefetch_unit.sv - directed bench with memory model and fetch scoreboard
module tb_if_prefetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Z = 1'b0, J = 1'b0, JR = 1'b0;
  logic [31:0] JumpAddr = '0, JrAddr = '0, BranchAddr = '0;
  logic        PC_IFWrite = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] Instruction_if;
  logic [31:0] NextPC_if;
  logic        IF_flush;

  int errors = 0;
  int checks = 0;
  int mem_lat = 1;
  int n_grants = 0;

  if_prefetch_unit #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .reset(reset), .Z(Z), .J(J), .JR(JR),
    .JumpAddr(JumpAddr), .JrAddr(JrAddr), .BranchAddr(BranchAddr),
    .PC_IFWrite(PC_IFWrite), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .Instruction_if(Instruction_if), .NextPC_if(NextPC_if),
    .IF_flush(IF_flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, input int max_cyc);
    int n = 0;
    while (!if_valid && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, if_valid, 1);
  endtask

  // Instruction memory: in-order responses, fixed latency, data = addr | A000_0000.
  typedef struct { logic [31:0] addr; int due; } mem_t;
  mem_t mq[$];
  int   cyc = 0;
  bit   rst_s;
  always @(posedge clk) begin
    rst_s = reset;
    cyc++;
    if (rst_s) begin
      mq.delete();
    end else begin
      if (imem_rvalid && mq.size() > 0) void'(mq.pop_front());
      if (imem_req && imem_gnt) mq.push_back('{imem_addr, cyc + mem_lat - 1});
    end
    #1;
    if (!rst_s && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mq[0].addr | 32'hA000_0000;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  end

  // Scoreboard: expected fetch PCs pushed on grant, popped when IF/ID accepts.
  logic [31:0] exp_q[$];
  logic [31:0] model_pc = '0;
  logic [31:0] e, tgt;
  logic        redir;
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_req", imem_req, 0);
      chk("rst_valid", if_valid, 0);
      chk("rst_instr", Instruction_if, 0);
      chk("rst_npc", NextPC_if, 0);
      chk("rst_flush", IF_flush, 0);
      exp_q.delete();
      model_pc = 32'h0;
    end else begin
      redir = Z | J | JR;
      chk("flush", IF_flush, redir);
      if (!if_valid) begin
        chk("idle_instr", Instruction_if, 0);
        chk("idle_npc", NextPC_if, 0);
      end
      if (if_valid && PC_IFWrite && !redir) begin
        chk("sb_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("pop_instr", Instruction_if, e | 32'hA000_0000);
          chk("pop_npc", NextPC_if, e + 32'd4);
        end
      end
      if (redir) begin
        chk("redir_req", imem_req, 0);
        tgt = JR ? JrAddr : (J ? JumpAddr : BranchAddr);
        exp_q.delete();
        model_pc = tgt & ~32'h3;
      end else if (imem_req && imem_gnt) begin
        chk("fetch_addr", imem_addr, model_pc);
        exp_q.push_back(model_pc);
        model_pc = model_pc + 32'd4;
        n_grants++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset and linear fetch; redirect inputs during reset must not flush.
    tick(); Z = 1'b1; BranchAddr = 32'd8;
    tick(); reset = 1'b0; Z = 1'b0;
    sample(); chk("lat_req", imem_req, 1); chk("lat_addr", imem_addr, 0); chk("lat_v0", if_valid, 0);
    sample(); chk("lat_v1", if_valid, 0);
    sample(); chk("lat_v2", if_valid, 1);
    chk("lat_instr", Instruction_if, 32'hA000_0000); chk("lat_npc", NextPC_if, 4);
    repeat (8) sample();

    // Stall until the queue is full, then release.
    tick(); reset = 1'b1; PC_IFWrite = 1'b0;
    tick();
    tick(); reset = 1'b0; n_grants = 0;
    repeat (10) sample();
    chk("full_grants", n_grants, 4); chk("full_req", imem_req, 0);
    chk("full_valid", if_valid, 1); chk("full_head", Instruction_if, 32'hA000_0000);
    tick(); PC_IFWrite = 1'b1;
    sample(); chk("rel_req0", imem_req, 0);
    sample(); chk("rel_req1", imem_req, 1); chk("rel_addr", imem_addr, 16);
    repeat (4) sample();

    // Redirect priority JR > J > Z.
    tick(); JR = 1'b1; J = 1'b1; Z = 1'b1; JrAddr = 32'd52; JumpAddr = 32'd44; BranchAddr = 32'd4;
    sample(); chk("pri_flush", IF_flush, 1); chk("pri_req", imem_req, 0);
    tick(); JR = 1'b0; J = 1'b0; Z = 1'b0;
    sample(); chk("pri_flush_off", IF_flush, 0); chk("pri_addr", imem_addr, 52);
    chk("pri_req1", imem_req, 1); chk("pri_v0", if_valid, 0);
    sample(); chk("pri_v1", if_valid, 0);
    sample(); chk("pri_v2", if_valid, 1);
    chk("pri_instr", Instruction_if, 32'hA000_0034); chk("pri_npc", NextPC_if, 56);

    // Jump with three fetches in flight on a 3-cycle memory.
    tick(); reset = 1'b1; mem_lat = 3;
    tick();
    tick(); reset = 1'b0;
    tick();
    tick();
    tick(); J = 1'b1; JumpAddr = 32'd46;
    sample(); chk("drop_flush", IF_flush, 1); chk("drop_rvalid", imem_rvalid, 1);
    tick(); J = 1'b0;
    sample(); chk("drop_addr", imem_addr, 44); chk("drop_req", imem_req, 1);
    wait_valid("drop_valid", 12);
    chk("drop_instr", Instruction_if, 32'hA000_002C); chk("drop_npc", NextPC_if, 48);

    // Branch in a cycle with a live response and a poppable head.
    tick(); reset = 1'b1; mem_lat = 2;
    tick();
    tick(); reset = 1'b0;
    repeat (8) tick();
    Z = 1'b1; BranchAddr = 32'd100;
    sample(); chk("brp_valid", if_valid, 1); chk("brp_rvalid", imem_rvalid, 1); chk("brp_flush", IF_flush, 1);
    tick(); Z = 1'b0;
    sample(); chk("brp_nopop", if_valid, 0); chk("brp_addr", imem_addr, 100); chk("brp_req", imem_req, 1);
    wait_valid("brp_v", 12);
    chk("brp_instr", Instruction_if, 32'hA000_0064); chk("brp_npc", NextPC_if, 104);

    // Reset while full with responses still outstanding.
    tick(); reset = 1'b1; mem_lat = 3; PC_IFWrite = 1'b0;
    tick();
    tick(); reset = 1'b0;
    repeat (4) tick();
    sample(); chk("mid_full_req", imem_req, 0);
    tick(); reset = 1'b1;
    sample(); chk("mid_valid", if_valid, 0); chk("mid_req", imem_req, 0);
    tick(); reset = 1'b0; PC_IFWrite = 1'b1;
    sample(); chk("mid_addr", imem_addr, 0); chk("mid_req1", imem_req, 1);
    wait_valid("mid_v", 8);
    chk("mid_instr", Instruction_if, 32'hA000_0000);

    // Random grant and stall pattern on a 1-cycle memory.
    mem_lat = 1;
    repeat (40) begin
      tick();
      imem_gnt   = 1'($urandom_range(0, 1));
      PC_IFWrite = 1'($urandom_range(0, 1));
    end
    tick(); imem_gnt = 1'b1; PC_IFWrite = 1'b1;
    repeat (10) sample();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
